pci_arbiter: RTL and testbench

- Central PCI bus arbiter, directly upstream of every Device instance.
- Samples each device's active-low req, drives that device's active-low gnt, and monitors shared Frame/IRDY to know when the bus is free.
- Round-robin fairness, one-cycle turnaround between owners, grant-to-Frame timeout, optional tenure preemption.

---
 rtl/pci_pkg.sv | 18 +
 rtl/rr_picker.sv | 29 ++
 rtl/pci_arbiter.sv | 122 ++++++++++++
 tb/tb_pci_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared PCI definitions: arbiter state encoding, default timing constants
// and the active-low signal levels used by the arbiter and the devices.
package pci_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam int DEF_TIMEOUT    = 16;
    localparam int DEF_MAX_TENURE = 32;

    localparam logic ASSERTED_N   = 1'b0;
    localparam logic DEASSERTED_N = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first active-high request found
// scanning last+1, last+2, ... modulo N.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IW'((int'(last) + i) % N);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant, one-cycle turnaround,
// grant-to-Frame timeout and optional tenure preemption.
module pci_arbiter
    import pci_pkg::*;
#(
    parameter  int NUM_DEV    = 4,
    parameter  int TIMEOUT    = DEF_TIMEOUT,
    parameter  int MAX_TENURE = DEF_MAX_TENURE,
    localparam int OW         = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DEV-1:0] req_n,
    input  logic               Frame,
    input  logic               IRDY,
    output logic [NUM_DEV-1:0] gnt_n,
    output logic [OW-1:0]      owner,
    output logic               owner_valid
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int NW = $clog2(MAX_TENURE + 2);

    arb_state_t         state, state_nx;
    logic [NUM_DEV-1:0] req_q;
    logic [OW-1:0]      last;
    logic [OW-1:0]      win;
    logic               win_vld;
    logic [TW-1:0]      tmo_cnt;
    logic [NW-1:0]      ten_cnt, ten_nx;
    logic               preempt;
    logic               frame_act, irdy_act, bus_idle;
    logic               own_req, other_req, tmo_hit, preempt_hit;

    // Only a clean 0 asserts the shared lines; a floating or unknown bus reads as idle.
    assign frame_act = (Frame === ASSERTED_N);
    assign irdy_act  = (IRDY === ASSERTED_N);
    assign bus_idle  = !frame_act && !irdy_act;

    assign own_req     = (req_q[owner] == ASSERTED_N);
    assign other_req   = |(~req_q & ~(NUM_DEV'(1) << owner));
    assign tmo_hit     = (int'(tmo_cnt) + 1 >= TIMEOUT);
    assign ten_nx      = (ten_cnt == '1) ? ten_cnt : ten_cnt + 1'b1;
    assign preempt_hit = (MAX_TENURE != 0) && (int'(ten_nx) >= MAX_TENURE) && other_req;

    rr_picker #(.N(NUM_DEV)) u_picker (
        .req    (~req_q),
        .last   (last),
        .winner (win),
        .valid  (win_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= '1;
            owner   <= '0;
            last    <= OW'(NUM_DEV - 1);
            tmo_cnt <= '0;
            ten_cnt <= '0;
            preempt <= 1'b0;
        end else begin
            state <= state_nx;
            req_q <= req_n;
            case (state)
                IDLE: begin
                    if (state_nx == GRANT) begin
                        owner   <= win;
                        tmo_cnt <= '0;
                    end
                end
                GRANT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    ten_cnt <= '0;
                    preempt <= 1'b0;
                    if (state_nx == GAP) last <= owner;
                end
                BUSY: begin
                    ten_cnt <= ten_nx;
                    if (preempt_hit) preempt <= 1'b1;
                    if (state_nx == GAP) begin
                        last    <= owner;
                        preempt <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame takes precedence over both release conditions in GRANT.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_vld && bus_idle) state_nx = GRANT;
            GRANT: begin
                if (frame_act)                state_nx = BUSY;
                else if (!own_req || tmo_hit) state_nx = GAP;
            end
            BUSY:    if (bus_idle) state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt_n       = '1;
        owner_valid = 1'b0;
        case (state)
            GRANT: begin
                gnt_n[owner] = ASSERTED_N;
                owner_valid  = 1'b1;
            end
            BUSY: begin
                if (!preempt) gnt_n[owner] = ASSERTED_N;
                owner_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pci_arbiter.sv
// Randomized and directed bench for pci_arbiter against a round-robin
// reference model working at grant/transaction granularity.
module tb_pci_arbiter;

    localparam int N    = 4;
    localparam int OW   = 2;
    localparam int TMO  = 16;
    localparam int MAXT = 32;
    localparam logic [N-1:0] ALL_HI = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_n;
    logic          frame_drv, irdy_drv;
    wire           frame_bus, irdy_bus;
    logic [N-1:0]  gnt_n;
    logic [OW-1:0] owner;
    logic          owner_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int model_last;

    // Shared lines are open-drain with pull-ups; the bench only ever pulls them low.
    assign frame_bus = frame_drv ? 1'b0 : 1'bz;
    assign irdy_bus  = irdy_drv  ? 1'b0 : 1'bz;
    pullup (frame_bus);
    pullup (irdy_bus);

    pci_arbiter #(.NUM_DEV(N), .TIMEOUT(TMO), .MAX_TENURE(MAXT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_n       (req_n),
        .Frame       (frame_bus),
        .IRDY        (irdy_bus),
        .gnt_n       (gnt_n),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first active-low requester after 'last', wrapping modulo N.
    function automatic int rr_next(input logic [N-1:0] rq_n, input int last);
        int d;
        for (int i = 1; i <= N; i++) begin
            d = (last + i) % N;
            if (rq_n[d[OW-1:0]] == 1'b0) return d;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst) chk("onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
    end

    task automatic wait_grant(output int dev, output int idle);
        dev  = -1;
        idle = 0;
        for (int i = 0; i < 20; i++) begin
            if (gnt_n != ALL_HI) break;
            idle++;
            tick();
        end
        if (gnt_n == ALL_HI) begin
            chk("grant_wait", 32'(gnt_n), 32'(ALL_HI ^ 4'b0001));
        end else begin
            for (int j = 0; j < N; j++)
                if (gnt_n[j[OW-1:0]] == 1'b0) dev = j;
        end
    endtask

    // Granted master runs Frame low for len cycles, then an IRDY tail, then releases.
    task automatic run_txn(input int dev, input int len, input int tail, input bit drop_req);
        frame_drv = 1'b1;
        if (drop_req) req_n[dev[OW-1:0]] = 1'b1;
        repeat (len) begin
            tick();
            chk("txn_hold", 32'(gnt_n), 32'(ALL_HI ^ (N'(1) << dev)));
        end
        frame_drv = 1'b0;
        irdy_drv  = (tail > 0);
        repeat (tail) begin
            tick();
            chk("irdy_tail_busy", 32'(owner_valid), 32'd1);
        end
        irdy_drv = 1'b0;
        tick();
        chk("gap_gnt", 32'(gnt_n), 32'(ALL_HI));
        chk("gap_valid", 32'(owner_valid), 32'd0);
        chk("gap_owner", 32'(owner), 32'(dev));
        model_last = dev;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int dev, idle, cnt, first_hi, exp, mode;
        logic [N-1:0] rq;

        rst = 1'b1; req_n = ALL_HI; frame_drv = 1'b0; irdy_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt_n), 32'(ALL_HI));
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_valid", 32'(owner_valid), 32'd0);
        #2 rst = 1'b0;
        model_last = N - 1;

        // Basic latency and single transaction with an IRDY tail
        req_n = 4'b1110;
        tick();
        chk("lat_edge1", 32'(gnt_n), 32'(ALL_HI));
        tick();
        chk("lat_edge2", 32'(gnt_n), 32'(4'b1110));
        chk("lat_owner", 32'(owner), 32'd0);
        chk("lat_valid", 32'(owner_valid), 32'd1);
        run_txn(0, 3, 1, 1'b1);

        // Timeout on device 2, then device 3 wins
        req_n = 4'b1011;
        wait_grant(dev, idle);
        chk("tmo_win", 32'(dev), 32'(rr_next(4'b1011, model_last)));
        chk("tmo_gnt", 32'(gnt_n), 32'(4'b1011));
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (gnt_n[2]) break;
            cnt++;
            tick();
        end
        chk("tmo_len", 32'(cnt), 32'(TMO));
        chk("tmo_valid", 32'(owner_valid), 32'd0);
        model_last = 2;
        req_n = 4'b0011;
        wait_grant(dev, idle);
        chk("after_tmo_win", 32'(dev), 32'(rr_next(4'b0011, model_last)));
        // Frame arrives on the same edge the timeout would fire
        repeat (TMO - 1) tick();
        run_txn(dev, 2, 0, 1'b1);

        // Preemption of device 1 by device 3
        req_n = 4'b1101;
        wait_grant(dev, idle);
        chk("pre_win", 32'(dev), 32'(rr_next(4'b1101, model_last)));
        frame_drv = 1'b1;
        req_n = ALL_HI;
        first_hi = -1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 5) req_n[3] = 1'b0;
            if (first_hi < 0 && gnt_n[1]) first_hi = c;
            if (!gnt_n[3] || !owner_valid) cnt++;
        end
        chk("preempt_at", 32'(first_hi), 32'(MAXT));
        chk("preempt_stays_busy", 32'(cnt), 32'd0);
        frame_drv = 1'b0;
        tick();
        chk("pre_gap", 32'(gnt_n), 32'(ALL_HI));
        model_last = 1;
        wait_grant(dev, idle);
        chk("pre_next_win", 32'(dev), 32'(rr_next(4'b0111, model_last)));
        run_txn(dev, 2, 0, 1'b1);

        // Asynchronous reset during BUSY
        req_n = 4'b1011;
        wait_grant(dev, idle);
        chk("rstb_win", 32'(dev), 32'(rr_next(4'b1011, model_last)));
        frame_drv = 1'b1;
        req_n = ALL_HI;
        tick();
        tick();
        chk("rstb_busy", 32'(gnt_n), 32'(4'b1011));
        #3 rst = 1'b1;
        #1;
        chk("rst_async_gnt", 32'(gnt_n), 32'(ALL_HI));
        chk("rst_async_valid", 32'(owner_valid), 32'd0);
        frame_drv = 1'b0;
        req_n = 4'b0000;
        #3 rst = 1'b0;
        model_last = N - 1;

        // Everyone requesting: strict rotation 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            wait_grant(dev, idle);
            if (k == 0) chk("rst_prio", 32'(dev), 32'd0);
            else        chk("rr_gap", 32'(idle >= 1), 32'd1);
            chk("rr_order", 32'(dev), 32'(rr_next(4'b0000, model_last)));
            chk("rr_seq", 32'(dev), 32'(k % N));
            run_txn(dev, 2, 0, 1'b0);
        end
        req_n = ALL_HI;

        // Undriven shared lines read as idle
        req_n = 4'b1101;
        wait_grant(dev, idle);
        chk("z_bus_gnt", 32'(gnt_n), 32'(4'b1101));
        run_txn(dev, 1, 0, 1'b1);

        // Randomized request patterns and master behaviours
        for (int it = 0; it < 40; it++) begin
            rq = N'($urandom_range(1, (1 << N) - 1));
            req_n = ~rq;
            exp = rr_next(req_n, model_last);
            wait_grant(dev, idle);
            chk("rnd_win", 32'(dev), 32'(exp));
            if (dev < 0) continue;
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                req_n[dev[OW-1:0]] = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    tick();
                    if (gnt_n == ALL_HI) break;
                end
                chk("abandon_drop", 32'(gnt_n), 32'(ALL_HI));
                chk("abandon_valid", 32'(owner_valid), 32'd0);
                model_last = dev;
            end else begin
                run_txn(dev, $urandom_range(1, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
